// File: rtl/bus_perm_pipe.sv
// bus_perm_pipe
//   Registered lane permutator. Each output lane picks one input lane through
//   a runtime-loadable select table and can be forced to zero by a per-lane
//   mask. The result sits in a one-deep valid/ready output register.
//   In STRICT mode, a select table that is not a bijection is refused.
//   A free-running counter of accepted input beats is exposed for debug.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   cfg_we     load cfg_sel / cfg_mask into the active table this cycle
//   cfg_sel    lane i select at [i*SELW +: SELW]
//   cfg_mask   1 = output lane i enabled, 0 = forced to zero
//   cfg_err    one-cycle pulse the cycle after a refused load
//   in_valid   din is valid
//   in_ready   block can take din (combinational, no in_valid dependency)
//   din        input lanes, lane j at [j*LW +: LW]
//   out_valid  dout is valid
//   out_ready  downstream takes dout
//   dout       permuted and masked lanes
//   beat_cnt   number of accepted input beats, wraps silently
module bus_perm_pipe #(
  parameter int LANES  = 8,
  parameter int LW     = 4,
  parameter int SELW   = $clog2(LANES),
  parameter bit STRICT = 1'b0,
  parameter int CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [LANES*SELW-1:0] cfg_sel,
  input  logic [LANES-1:0]      cfg_mask,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*LW-1:0]   din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LW-1:0]   dout,
  output logic [CNTW-1:0]       beat_cnt
);

  function automatic logic [LANES*SELW-1:0] identity_table();
    logic [LANES*SELW-1:0] t;
    t = '0;
    for (int i = 0; i < LANES; i++) begin
      t[i*SELW +: SELW] = SELW'(i);
    end
    return t;
  endfunction

  localparam logic [LANES*SELW-1:0] IDENTITY = identity_table();

  logic [LANES*SELW-1:0] sel_q;
  logic [LANES-1:0]      mask_q;
  logic [LANES*LW-1:0]   perm_data;
  logic [SELW-1:0]       lane_sel;
  logic [SELW-1:0]       cfg_lane;
  logic [LANES-1:0]      seen;
  logic                  cfg_ok;
  logic                  accept;

  // The output register frees up either when it is empty or when its
  // current content leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Permutation through the active table. Selects that point past the last
  // lane (possible only when LANES is not a power of two) yield zero.
  always_comb begin
    perm_data = '0;
    lane_sel  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sel = sel_q[i*SELW +: SELW];
      if (mask_q[i] && (int'(lane_sel) < LANES)) begin
        perm_data[i*LW +: LW] = din[lane_sel*LW +: LW];
      end
    end
  end

  // Bijection check on the incoming table: every select in range and no
  // value used twice. The mask plays no part. Non-strict builds accept all.
  always_comb begin
    seen     = '0;
    cfg_ok   = 1'b1;
    cfg_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      cfg_lane = cfg_sel[i*SELW +: SELW];
      if (int'(cfg_lane) >= LANES) begin
        cfg_ok = 1'b0;
      end else if (seen[cfg_lane]) begin
        cfg_ok = 1'b0;
      end else begin
        seen[cfg_lane] = 1'b1;
      end
    end
    if (!STRICT) begin
      cfg_ok = 1'b1;
    end
  end

  // Table, output register and counter. The permutation above reads the
  // table before this edge, so a beat accepted alongside a load uses the
  // old table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= IDENTITY;
      mask_q    <= '1;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      beat_cnt  <= '0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        sel_q  <= cfg_sel;
        mask_q <= cfg_mask;
      end
      if (accept) begin
        dout      <= perm_data;
        out_valid <= 1'b1;
        beat_cnt  <= beat_cnt + CNTW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_perm_pipe.sv
// tb_bus_perm_pipe
//   Drives four bus_perm_pipe instances from shared stimulus:
//     inst0: 8 lanes, non-strict, 16-bit counter
//     inst1: 8 lanes, strict,     4-bit counter
//     inst2: 6 lanes, non-strict (out-of-range selects give zero)
//     inst3: 6 lanes, strict     (out-of-range selects are refused)
//   A lane-level reference model written with plain arithmetic tracks the
//   expected table, output register and counter of each instance.
module tb_bus_perm_pipe;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [23:0] cfg_sel;
  logic [7:0]  cfg_mask;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] din;

  wire  [3:0]  ov;
  wire  [3:0]  ir;
  wire  [3:0]  er;
  wire  [31:0] dout0;
  wire  [31:0] dout1;
  wire  [23:0] dout2;
  wire  [23:0] dout3;
  wire  [15:0] cnt0;
  wire  [3:0]  cnt1;
  wire  [15:0] cnt2;
  wire  [15:0] cnt3;

  wire  [31:0] dout_a [4];
  wire  [15:0] cnt_a  [4];

  assign dout_a[0] = dout0;
  assign dout_a[1] = dout1;
  assign dout_a[2] = {8'h00, dout2};
  assign dout_a[3] = {8'h00, dout3};
  assign cnt_a[0]  = cnt0;
  assign cnt_a[1]  = {12'h000, cnt1};
  assign cnt_a[2]  = cnt2;
  assign cnt_a[3]  = cnt3;

  bus_perm_pipe #(.LANES(8), .LW(4), .STRICT(1'b0), .CNTW(16)) u_dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mask(cfg_mask),
    .cfg_err(er[0]), .in_valid(in_valid), .in_ready(ir[0]), .din(din),
    .out_valid(ov[0]), .out_ready(out_ready), .dout(dout0), .beat_cnt(cnt0));

  bus_perm_pipe #(.LANES(8), .LW(4), .STRICT(1'b1), .CNTW(4)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mask(cfg_mask),
    .cfg_err(er[1]), .in_valid(in_valid), .in_ready(ir[1]), .din(din),
    .out_valid(ov[1]), .out_ready(out_ready), .dout(dout1), .beat_cnt(cnt1));

  bus_perm_pipe #(.LANES(6), .LW(4), .STRICT(1'b0), .CNTW(16)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel[17:0]), .cfg_mask(cfg_mask[5:0]),
    .cfg_err(er[2]), .in_valid(in_valid), .in_ready(ir[2]), .din(din[23:0]),
    .out_valid(ov[2]), .out_ready(out_ready), .dout(dout2), .beat_cnt(cnt2));

  bus_perm_pipe #(.LANES(6), .LW(4), .STRICT(1'b1), .CNTW(16)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel[17:0]), .cfg_mask(cfg_mask[5:0]),
    .cfg_err(er[3]), .in_valid(in_valid), .in_ready(ir[3]), .din(din[23:0]),
    .out_valid(ov[3]), .out_ready(out_ready), .dout(dout3), .beat_cnt(cnt3));

  // Per-instance configuration of the reference model.
  int          lanes_k  [4] = '{8, 8, 6, 6};
  bit          strict_k [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int          cntw_k   [4] = '{16, 4, 16, 16};

  // Reference model state.
  logic        m_valid;
  logic [31:0] m_dout [4];
  logic [23:0] m_sel  [4];
  logic [7:0]  m_mask [4];
  int unsigned m_cnt  [4];
  logic        m_err  [4];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] ident(input int lanes);
    logic [23:0] t;
    t = '0;
    for (int i = 0; i < lanes; i++) t = t | (24'(i) << (3 * i));
    return t;
  endfunction

  function automatic logic [23:0] reversed8();
    logic [23:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) t = t | (24'(7 - i) << (3 * i));
    return t;
  endfunction

  function automatic int sel_of(input logic [23:0] sel, input int i);
    return int'((sel >> (3 * i)) & 24'h7);
  endfunction

  // Output lane i takes input lane sel[i] when enabled and in range.
  function automatic logic [31:0] perm(input logic [31:0] d, input logic [23:0] sel,
                                       input logic [7:0] mask, input int lanes);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      s = sel_of(sel, i);
      if (mask[i] && s < lanes) r = r | (((d >> (4 * s)) & 32'hF) << (4 * i));
    end
    return r;
  endfunction

  function automatic bit is_perm(input logic [23:0] sel, input int lanes);
    bit [7:0] used;
    int s;
    used = '0;
    for (int i = 0; i < lanes; i++) begin
      s = sel_of(sel, i);
      if (s >= lanes) return 1'b0;
      if (used[s]) return 1'b0;
      used[s] = 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic logic [23:0] shuffled(input int lanes);
    int p [8];
    int j;
    int t;
    logic [23:0] r;
    for (int i = 0; i < 8; i++) p[i] = i;
    for (int i = lanes - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = p[i];
      p[i] = p[j];
      p[j] = t;
    end
    for (int i = lanes; i < 8; i++) p[i] = int'($urandom_range(0, 7));
    r = '0;
    for (int i = 0; i < 8; i++) r = r | (24'(p[i]) << (3 * i));
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_dout[k] = '0;
      m_sel[k]  = ident(lanes_k[k]);
      m_mask[k] = 8'hFF;
      m_cnt[k]  = 0;
      m_err[k]  = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven,
  // then let the DUT take the same edge and settle.
  task automatic step();
    bit acc;
    bit ok;
    acc = in_valid && (!m_valid || out_ready);
    for (int k = 0; k < 4; k++) begin
      ok = !strict_k[k] || is_perm(cfg_sel, lanes_k[k]);
      if (acc) begin
        m_dout[k] = perm(din, m_sel[k], m_mask[k], lanes_k[k]);
        m_cnt[k]  = (m_cnt[k] + 1) % (32'd1 << cntw_k[k]);
      end
      m_err[k] = cfg_we && !ok;
      if (cfg_we && ok) begin
        m_sel[k]  = cfg_sel;
        m_mask[k] = cfg_mask;
      end
    end
    if (acc) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_mask  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks += 5;
      if (ov[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid inst%0d got %b expected 0", k, ov[k]); end
      if (er[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_err inst%0d got %b expected 0", k, er[k]); end
      if (dout_a[k] !== 32'h0) begin errors++; $display("[TB] FAIL reset_dout inst%0d got %h expected 0", k, dout_a[k]); end
      if (cnt_a[k] !== 16'h0) begin errors++; $display("[TB] FAIL reset_beat_cnt inst%0d got %0d expected 0", k, cnt_a[k]); end
      if (ir[k] !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready inst%0d got %b expected 1", k, ir[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    din = 32'h76543210; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks += 4;
    if (ov[0] !== 1'b1) begin errors++; $display("[TB] FAIL ident_out_valid got %b expected 1", ov[0]); end
    if (dout0 !== 32'h76543210) begin errors++; $display("[TB] FAIL ident_dout8 got %h expected 76543210", dout0); end
    if (dout2 !== 24'h543210) begin errors++; $display("[TB] FAIL ident_dout6 got %h expected 543210", dout2); end
    if (cnt0 !== 16'd1) begin errors++; $display("[TB] FAIL ident_beat_cnt got %0d expected 1", cnt0); end
    step();
    checks += 2;
    if (ov[0] !== 1'b0) begin errors++; $display("[TB] FAIL drain_out_valid got %b expected 0", ov[0]); end
    if (dout0 !== 32'h76543210) begin errors++; $display("[TB] FAIL drain_dout_hold got %h expected 76543210", dout0); end
  endtask

  task automatic test_reverse_mask();
    cfg_sel = reversed8(); cfg_mask = 8'hFF; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    checks += 2;
    if (er[0] !== 1'b0) begin errors++; $display("[TB] FAIL rev_err_nonstrict got %b expected 0", er[0]); end
    if (er[3] !== 1'b1) begin errors++; $display("[TB] FAIL rev_err_range6 got %b expected 1", er[3]); end
    din = 32'h76543210; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks += 4;
    if (dout0 !== 32'h01234567) begin errors++; $display("[TB] FAIL rev_dout_inst0 got %h expected 01234567", dout0); end
    if (dout1 !== 32'h01234567) begin errors++; $display("[TB] FAIL rev_dout_inst1 got %h expected 01234567", dout1); end
    if (dout2 !== 24'h234500) begin errors++; $display("[TB] FAIL rev_dout_outofrange got %h expected 234500", dout2); end
    if (dout3 !== 24'h543210) begin errors++; $display("[TB] FAIL rev_dout_kept got %h expected 543210", dout3); end
    cfg_mask = 8'hF0; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks += 2;
    if (dout0 !== 32'h01230000) begin errors++; $display("[TB] FAIL mask_dout8 got %h expected 01230000", dout0); end
    if (dout2 !== 24'h230000) begin errors++; $display("[TB] FAIL mask_dout6 got %h expected 230000", dout2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sendq [$];
    logic [31:0] recvq [$];
    logic [31:0] expq  [$];
    bit acc;
    cfg_sel = ident(8); cfg_mask = 8'hFF; cfg_we = 1'b1; out_ready = 1'b1;
    step();
    cfg_we = 1'b0;
    sendq = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};
    expq  = sendq;
    for (int c = 0; c < 30 && recvq.size() < 3; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      in_valid  = sendq.size() > 0;
      din       = (sendq.size() > 0) ? sendq[0] : 32'h0;
      #1;
      if (c >= 1 && c <= 3) begin
        checks += 3;
        if (ov[0] !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_valid cyc%0d got %b expected 1", c, ov[0]); end
        if (dout0 !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL stall_dout cyc%0d got %h expected aaaaaaaa", c, dout0); end
        if (ir[0] !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready cyc%0d got %b expected 0", c, ir[0]); end
      end
      if (ov[0] && out_ready) recvq.push_back(dout0);
      acc = in_valid && (!m_valid || out_ready);
      step();
      if (acc) void'(sendq.pop_front());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (recvq.size() != 3) begin
      errors++; $display("[TB] FAIL stall_count got %0d expected 3", recvq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (recvq[i] !== expq[i]) begin errors++; $display("[TB] FAIL stall_order beat%0d got %h expected %h", i, recvq[i], expq[i]); end
      end
    end
  endtask

  task automatic test_strict();
    cfg_sel = (ident(8) & ~24'h3F) | 24'h1B; cfg_mask = 8'hFF; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    checks += 3;
    if (er[1] !== 1'b1) begin errors++; $display("[TB] FAIL strict_err got %b expected 1", er[1]); end
    if (er[3] !== 1'b1) begin errors++; $display("[TB] FAIL strict_err6 got %b expected 1", er[3]); end
    if (er[0] !== 1'b0) begin errors++; $display("[TB] FAIL nonstrict_err got %b expected 0", er[0]); end
    din = 32'h76543210; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks += 4;
    if (er[1] !== 1'b0) begin errors++; $display("[TB] FAIL strict_err_pulse got %b expected 0", er[1]); end
    if (dout1 !== 32'h76543210) begin errors++; $display("[TB] FAIL strict_old_table got %h expected 76543210", dout1); end
    if (dout0 !== 32'h76543233) begin errors++; $display("[TB] FAIL broadcast8 got %h expected 76543233", dout0); end
    if (dout2 !== 24'h543233) begin errors++; $display("[TB] FAIL broadcast6 got %h expected 543233", dout2); end
    cfg_we = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (er[1] !== 1'b1) begin errors++; $display("[TB] FAIL strict_b2b_err load%0d got %b expected 1", i, er[1]); end
    end
    cfg_we = 1'b0;
    step();
    checks++;
    if (er[1] !== 1'b0) begin errors++; $display("[TB] FAIL strict_b2b_end got %b expected 0", er[1]); end
  endtask

  task automatic test_cfg_same_cycle();
    cfg_sel = ident(8); cfg_mask = 8'hFF; cfg_we = 1'b1; out_ready = 1'b1;
    step();
    cfg_sel = reversed8(); din = 32'h76543210; in_valid = 1'b1;
    step();
    cfg_we = 1'b0;
    checks++;
    if (dout0 !== 32'h76543210) begin errors++; $display("[TB] FAIL samecyc_beatA got %h expected 76543210", dout0); end
    din = 32'hFEDCBA98;
    step();
    in_valid = 1'b0;
    checks += 3;
    if (dout0 !== 32'h89ABCDEF) begin errors++; $display("[TB] FAIL samecyc_beatB got %h expected 89abcdef", dout0); end
    if (dout2 !== 24'hABCD00) begin errors++; $display("[TB] FAIL samecyc_beatB6 got %h expected abcd00", dout2); end
    if (dout3 !== 24'hDCBA98) begin errors++; $display("[TB] FAIL samecyc_beatB6s got %h expected dcba98", dout3); end
  endtask

  task automatic test_reset_mid();
    din = 32'h76543210; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (ov[0] !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid got %b expected 1", ov[0]); end
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (ov[k] !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid inst%0d got %b expected 0", k, ov[k]); end
      if (dout_a[k] !== 32'h0) begin errors++; $display("[TB] FAIL midrst_dout inst%0d got %h expected 0", k, dout_a[k]); end
      if (cnt_a[k] !== 16'h0) begin errors++; $display("[TB] FAIL midrst_cnt inst%0d got %0d expected 0", k, cnt_a[k]); end
    end
    rst = 1'b0;
    din = 32'h76543210; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks += 3;
    if (dout0 !== 32'h76543210) begin errors++; $display("[TB] FAIL midrst_identity got %h expected 76543210", dout0); end
    if (dout2 !== 24'h543210) begin errors++; $display("[TB] FAIL midrst_identity6 got %h expected 543210", dout2); end
    if (cnt0 !== 16'd1) begin errors++; $display("[TB] FAIL midrst_cnt_after got %0d expected 1", cnt0); end
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      din = $urandom;
      step();
      if (i == 15) begin
        checks++;
        if (cnt1 !== 4'd0) begin errors++; $display("[TB] FAIL wrap_at16 got %0d expected 0", cnt1); end
      end
    end
    in_valid = 1'b0;
    checks += 2;
    if (cnt1 !== 4'd1) begin errors++; $display("[TB] FAIL wrap_cnt got %0d expected 1", cnt1); end
    if (cnt0 !== 16'd17) begin errors++; $display("[TB] FAIL wrap_cnt16 got %0d expected 17", cnt0); end
  endtask

  task automatic test_random();
    int mode;
    bit exp_ready;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      din       = $urandom;
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_mask  = 8'($urandom);
      mode      = int'($urandom_range(0, 2));
      if (mode == 0) cfg_sel = shuffled(8);
      else if (mode == 1) cfg_sel = 24'($urandom);
      else cfg_sel = shuffled(6);
      #1;
      exp_ready = !m_valid || out_ready;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ir[k] !== exp_ready) begin errors++; $display("[TB] FAIL rnd_in_ready cyc%0d inst%0d got %b expected %b", c, k, ir[k], exp_ready); end
      end
      step();
      for (int k = 0; k < 4; k++) begin
        checks += 4;
        if (ov[k] !== m_valid) begin errors++; $display("[TB] FAIL rnd_out_valid cyc%0d inst%0d got %b expected %b", c, k, ov[k], m_valid); end
        if (dout_a[k] !== m_dout[k]) begin errors++; $display("[TB] FAIL rnd_dout cyc%0d inst%0d got %h expected %h", c, k, dout_a[k], m_dout[k]); end
        if (er[k] !== m_err[k]) begin errors++; $display("[TB] FAIL rnd_cfg_err cyc%0d inst%0d got %b expected %b", c, k, er[k], m_err[k]); end
        if (cnt_a[k] !== 16'(m_cnt[k])) begin errors++; $display("[TB] FAIL rnd_beat_cnt cyc%0d inst%0d got %0d expected %0d", c, k, cnt_a[k], m_cnt[k]); end
      end
    end
    cfg_we = 1'b0;
    in_valid = 1'b0;
  endtask

  // Bound on total run time so a stuck design still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    cfg_we = 1'b0;
    cfg_sel = '0;
    cfg_mask = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din = '0;
    #1;
    test_reset();
    test_identity();
    test_reverse_mask();
    test_back_to_back();
    test_strict();
    test_cfg_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
